// File: rtl/mem_bus_access.sv
// MEM-stage data-bus access unit: turns load/store flags into a req/ack RAM
// transaction, stalls the pipeline until it completes and holds the returned
// word for MEM/WB. Sub-word extraction and sign extension happen in WB.
module mem_bus_access #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_current_stage,
  input  logic              mem_read_flag_in,
  input  logic              mem_write_flag_in,
  input  logic [SEL_W-1:0]  mem_sel_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_write_data_in,
  output logic              ram_req,
  output logic [SEL_W-1:0]  ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_addr_ok,
  input  logic              ram_data_ok,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_request,
  output logic [DATA_W-1:0] ram_read_data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [DATA_W-1:0] r_rdata;
  logic              w_access;
  logic              w_latch;
  logic              w_req;
  logic              w_stall;
  logic [1:0]        w_unused_addr_lsb;

  assign w_access          = mem_read_flag_in | mem_write_flag_in;
  assign w_unused_addr_lsb = mem_addr_in[1:0];

  assign ram_we            = mem_write_flag_in ? mem_sel_in : '0;
  assign ram_addr          = {mem_addr_in[ADDR_W-1:2], 2'b00};
  assign ram_wdata         = mem_write_data_in;
  assign ram_read_data_out = r_rdata;

  // Requests are suppressed while reset is asserted: anything accepted then
  // would be abandoned at the reset edge anyway.
  assign ram_req       = w_req & rst;
  assign stall_request = w_stall & rst;

  // Next-state, request/stall decode and data-latch strobe.
  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access && !flush) begin
          w_req   = 1'b1;
          w_stall = 1'b1;
          if (ram_addr_ok) begin
            if (ram_data_ok) begin
              w_latch = 1'b1;
              w_next  = S_DONE;
            end else begin
              w_next  = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (ram_data_ok) begin
          if (flush) begin
            w_next  = S_IDLE;
          end else begin
            w_latch = 1'b1;
            w_next  = S_DONE;
          end
        end else if (flush) begin
          w_next = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush || !stall_current_stage) w_next = S_IDLE;
      end
      default: begin
        w_stall = 1'b1;
        if (ram_data_ok) w_next = S_IDLE;
      end
    endcase
  end

  // State and captured read word; synchronous active-low reset wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) r_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_access.sv
// Testbench for mem_bus_access: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_bus_access;

  logic        clk = 1'b0;
  logic        rst, flush, stall_current_stage;
  logic        mem_read_flag_in, mem_write_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_addr_in, mem_write_data_in;
  logic        ram_req, ram_addr_ok, ram_data_ok, stall_request;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, ram_read_data_out;

  always #5 clk = ~clk;

  mem_bus_access #(.DATA_W(32), .ADDR_W(32), .SEL_W(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_current_stage(stall_current_stage),
    .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
    .mem_sel_in(mem_sel_in), .mem_addr_in(mem_addr_in),
    .mem_write_data_in(mem_write_data_in),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok), .ram_rdata(ram_rdata),
    .stall_request(stall_request), .ram_read_data_out(ram_read_data_out)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: one transaction in flight (m_busy), whether its answer is
  // to be thrown away (m_drop), whether a finished access is still in MEM
  // (m_held), and the word MEM/WB should see (m_data).
  bit          m_busy, m_drop, m_held;
  logic [31:0] m_data;
  bit          exp_stall_last;
  logic        obs_req, obs_stall;
  logic [31:0] obs_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit rst_v, input bit flush_v, input bit scs,
                      input bit rd, input bit wr, input logic [3:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input bit aok, input bit dok, input logic [31:0] rdata);
    bit issuing, exp_stall;
    @(negedge clk);
    rst = rst_v; flush = flush_v; stall_current_stage = scs;
    mem_read_flag_in = rd; mem_write_flag_in = wr; mem_sel_in = sel;
    mem_addr_in = addr; mem_write_data_in = wdata;
    ram_addr_ok = aok; ram_data_ok = dok; ram_rdata = rdata;
    #1;
    issuing   = rst_v && !m_busy && !m_held && (rd || wr) && !flush_v;
    exp_stall = rst_v && (issuing || m_busy);
    obs_req = ram_req; obs_stall = stall_request; obs_data = ram_read_data_out;
    check("ram_req",   {31'b0, ram_req},       {31'b0, issuing});
    check("stall_req", {31'b0, stall_request}, {31'b0, exp_stall});
    check("ram_we",    {28'b0, ram_we},        wr ? {28'b0, sel} : 32'h0);
    check("ram_addr",  ram_addr,               addr & 32'hFFFF_FFFC);
    check("ram_wdata", ram_wdata,              wdata);
    check("rd_data",   ram_read_data_out,      m_data);
    exp_stall_last = exp_stall;
    @(posedge clk);
    if (!rst_v) begin
      m_busy = 0; m_drop = 0; m_held = 0; m_data = 32'h0;
    end else if (m_held) begin
      m_held = scs && !flush_v;
    end else if (m_busy) begin
      if (dok) begin
        m_busy = 0;
        if (!m_drop && !flush_v) begin m_data = rdata; m_held = 1; end
        m_drop = 0;
      end else if (flush_v) begin
        m_drop = 1;
      end
    end else if (issuing && aok) begin
      if (dok) begin m_data = rdata; m_held = 1; end
      else m_busy = 1;
    end
  endtask

  int unsigned rq, st;
  bit          c_rd, c_wr, c_flush, c_scs, c_rst, c_aok, c_dok, prev_scs;
  logic [3:0]  c_sel;
  logic [31:0] c_addr, c_wdata;

  initial begin
    // Bring the DUT out of X before any checking.
    rst = 0; flush = 0; stall_current_stage = 0; mem_read_flag_in = 0;
    mem_write_flag_in = 0; mem_sel_in = 0; mem_addr_in = 0; mem_write_data_in = 0;
    ram_addr_ok = 0; ram_data_ok = 0; ram_rdata = 0;
    m_busy = 0; m_drop = 0; m_held = 0; m_data = 0;
    @(posedge clk);

    // Reset held with a load pending.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 4'hF, 32'h100, 0, 1, 1, 32'h5555_5555);
      check("rst_req", {31'b0, obs_req}, 0);
      check("rst_data", obs_data, 0);
    end

    // Zero-wait load.
    step(1, 0, 0, 1, 0, 4'b1100, 32'h8000_1236, 0, 1, 1, 32'hDEAD_BEEF);
    check("zw_stall0", {31'b0, obs_stall}, 1);
    step(1, 0, 0, 1, 0, 4'b1100, 32'h8000_1236, 0, 0, 0, 0);
    check("zw_stall1", {31'b0, obs_stall}, 0);
    check("zw_data", obs_data, 32'hDEAD_BEEF);

    // Delayed store: addr_ok in cycle 2, data_ok in cycle 5.
    rq = 0; st = 0;
    for (int c = 0; c < 8; c++) begin
      step(1, 0, 0, 0, c < 7, 4'b0011, 32'h10, 32'h0000_ABCD,
           c == 2, c == 5, 32'h7777_0000);
      rq += obs_req; st += obs_stall;
    end
    check("st_req_cycles", rq, 3);
    check("st_stall_cycles", st, 6);

    // Completed load held in DONE by the stall controller.
    step(1, 0, 0, 1, 0, 4'hF, 32'h40, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0, 4'hF, 32'h40, 0, 0, 1, 32'hCAFE_F00D);
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 1, 1, 0, 4'hF, 32'h40, 0, 0, 0, 32'h1111_1111);
      check("held_req", {31'b0, obs_req}, 0);
      check("held_data", obs_data, 32'hCAFE_F00D);
    end
    step(1, 0, 0, 1, 0, 4'hF, 32'h40, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0);

    // Flush while waiting: response drained and discarded.
    step(1, 0, 0, 1, 0, 4'hF, 32'h80, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 4'hF, 32'h80, 0, 0, 0, 0);
    check("fl_stall1", {31'b0, obs_stall}, 1);
    step(1, 0, 0, 1, 0, 4'hF, 32'h100, 0, 1, 0, 0);
    check("fl_stall2", {31'b0, obs_stall}, 1);
    check("fl_noreq2", {31'b0, obs_req}, 0);
    step(1, 0, 0, 1, 0, 4'hF, 32'h100, 0, 1, 1, 32'h1234_5678);
    check("fl_noreq3", {31'b0, obs_req}, 0);
    step(1, 0, 0, 1, 0, 4'hF, 32'h100, 0, 1, 1, 32'h0BAD_CAFE);
    check("fl_keep", obs_data, 32'hCAFE_F00D);
    check("fl_reissue", {31'b0, obs_req}, 1);
    step(1, 0, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 0);
    check("fl_newdata", obs_data, 32'h0BAD_CAFE);

    // Synchronous reset while waiting.
    step(1, 0, 0, 1, 0, 4'hF, 32'h200, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 4'hF, 32'h200, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4'hF, 32'h200, 0, 0, 0, 0);
    check("mr_stall", {31'b0, obs_stall}, 0);
    check("mr_data", obs_data, 0);

    // Randomized traffic; EX/MEM contents only advance when not stalled.
    exp_stall_last = 0; prev_scs = 0;
    c_rd = 0; c_wr = 0; c_sel = 0; c_addr = 0; c_wdata = 0;
    for (int n = 0; n < 3000; n++) begin
      if ((!exp_stall_last && !prev_scs) || c_flush) begin
        c_rd = ($urandom_range(0, 2) == 0);
        c_wr = !c_rd && ($urandom_range(0, 1) == 0);
        c_sel = 4'($urandom); c_addr = $urandom; c_wdata = $urandom;
      end
      c_rst   = ($urandom_range(0, 99) == 0);
      c_flush = ($urandom_range(0, 19) == 0);
      c_scs   = ($urandom_range(0, 3) == 0);
      c_aok   = ($urandom_range(0, 1) == 0);
      c_dok   = m_busy ? ($urandom_range(0, 2) == 0)
                       : (!m_held && c_aok && ($urandom_range(0, 1) == 0));
      step(!c_rst, c_flush, c_scs, c_rd, c_wr, c_sel, c_addr, c_wdata,
           c_aok, c_dok, $urandom);
      prev_scs = c_scs;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
